// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Four-digit multiplexed 7-segment display driver. Digit values are captured
// into a shadow register on loadIn and moved into the active (displayed)
// register only at the frame boundary, so a frame never mixes two values.
// Every digit slot starts with a short blanking gap to suppress ghosting.
//
// Ports:
//   clkIn        : clock
//   resetIn      : asynchronous, active-low reset
//   valueIn[15:0]: four nibbles, [3:0] = digit 0 (rightmost)
//   dpIn[3:0]    : decimal point per digit
//   loadIn       : single-cycle capture strobe for valueIn/dpIn
//   lzbEnableIn  : leading-zero blanking enable (live, not buffered)
//   segOut[6:0]  : segments a..g (bit0 = a)
//   dpOut        : decimal point of the active digit
//   digitOut[3:0]: one-hot digit enable, all inactive during blanking
//   digitIdxOut  : index of the current slot
//   frameDoneOut : one-cycle pulse on the last cycle of the digit-3 slot
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int SCAN_DIV         = 6750,
  parameter int BLANK_CYCLES     = 32,
  parameter bit SEG_ACTIVE_LOW   = 1'b1,
  parameter bit DIGIT_ACTIVE_LOW = 1'b1
) (
  input  logic        clkIn,
  input  logic        resetIn,
  input  logic [15:0] valueIn,
  input  logic [3:0]  dpIn,
  input  logic        loadIn,
  input  logic        lzbEnableIn,
  output logic [6:0]  segOut,
  output logic        dpOut,
  output logic [3:0]  digitOut,
  output logic [1:0]  digitIdxOut,
  output logic        frameDoneOut
);

  localparam int            CW        = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  // Hex digit to segment pattern, gfedcba, active-high.
  function automatic logic [6:0] hexDecode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h3F;
      4'h1:    pat = 7'h06;
      4'h2:    pat = 7'h5B;
      4'h3:    pat = 7'h4F;
      4'h4:    pat = 7'h66;
      4'h5:    pat = 7'h6D;
      4'h6:    pat = 7'h7D;
      4'h7:    pat = 7'h07;
      4'h8:    pat = 7'h7F;
      4'h9:    pat = 7'h6F;
      4'hA:    pat = 7'h77;
      4'hB:    pat = 7'h7C;
      4'hC:    pat = 7'h39;
      4'hD:    pat = 7'h5E;
      4'hE:    pat = 7'h79;
      4'hF:    pat = 7'h71;
      default: pat = 7'h00;
    endcase
    return pat;
  endfunction

  logic [CW-1:0] cnt_r;
  logic [1:0]    idx_r;
  logic [15:0]   shVal_r;
  logic [3:0]    shDp_r;
  logic [15:0]   acVal_r;
  logic [3:0]    acDp_r;
  logic          pending_r;

  logic [CW-1:0] cntNext_s;
  logic [1:0]    idxNext_s;
  logic [15:0]   shValNext_s;
  logic [3:0]    shDpNext_s;
  logic [15:0]   acValNext_s;
  logic [3:0]    acDpNext_s;
  logic          pendingNext_s;
  logic          wrap_s;
  logic          swap_s;

  logic [0:0]    stateNext_s;
  logic [3:0]    nibble_s;
  logic          dpSel_s;
  logic [3:0]    digitHot_s;
  logic [3:0]    lzbMask_s;
  logic [6:0]    segAct_s;
  logic          dpAct_s;
  logic [3:0]    digitAct_s;
  logic          frameDoneNext_s;

  // Next-state for the slot counter, digit index and the two value buffers.
  always_comb begin
    wrap_s = (cnt_r == CNT_LAST);
    swap_s = wrap_s && (idx_r == 2'd3);

    if (wrap_s) begin
      cntNext_s = '0;
      idxNext_s = idx_r + 2'd1;
    end else begin
      cntNext_s = cnt_r + CNT_ONE;
      idxNext_s = idx_r;
    end

    if (loadIn) begin
      shValNext_s = valueIn;
      shDpNext_s  = dpIn;
    end else begin
      shValNext_s = shVal_r;
      shDpNext_s  = shDp_r;
    end

    // A load landing on the swap edge bypasses the shadow so it is not
    // delayed by a whole frame.
    if (swap_s) begin
      if (loadIn) begin
        acValNext_s = valueIn;
        acDpNext_s  = dpIn;
      end else if (pending_r) begin
        acValNext_s = shVal_r;
        acDpNext_s  = shDp_r;
      end else begin
        acValNext_s = acVal_r;
        acDpNext_s  = acDp_r;
      end
      pendingNext_s = 1'b0;
    end else begin
      acValNext_s   = acVal_r;
      acDpNext_s    = acDp_r;
      pendingNext_s = loadIn ? 1'b1 : pending_r;
    end
  end

  // Output decode from next-state so the registered outputs line up with cnt/idx.
  always_comb begin
    stateNext_s = (cntNext_s < CNT_BLANK) ? ST_BLANK : ST_SHOW;

    case (idxNext_s)
      2'd0: begin
        nibble_s   = acValNext_s[3:0];
        dpSel_s    = acDpNext_s[0];
        digitHot_s = 4'b0001;
      end
      2'd1: begin
        nibble_s   = acValNext_s[7:4];
        dpSel_s    = acDpNext_s[1];
        digitHot_s = 4'b0010;
      end
      2'd2: begin
        nibble_s   = acValNext_s[11:8];
        dpSel_s    = acDpNext_s[2];
        digitHot_s = 4'b0100;
      end
      2'd3: begin
        nibble_s   = acValNext_s[15:12];
        dpSel_s    = acDpNext_s[3];
        digitHot_s = 4'b1000;
      end
      default: begin
        nibble_s   = 4'h0;
        dpSel_s    = 1'b0;
        digitHot_s = 4'b0000;
      end
    endcase

    // Digit n is a leading zero when it and every digit above it are zero;
    // digit 0 always shows so a zero value still reads "0".
    lzbMask_s[3] = (acValNext_s[15:12] == 4'h0);
    lzbMask_s[2] = lzbMask_s[3] && (acValNext_s[11:8] == 4'h0);
    lzbMask_s[1] = lzbMask_s[2] && (acValNext_s[7:4] == 4'h0);
    lzbMask_s[0] = 1'b0;

    segAct_s   = 7'h00;
    dpAct_s    = 1'b0;
    digitAct_s = 4'b0000;
    case (stateNext_s)
      ST_BLANK: begin
        segAct_s   = 7'h00;
        dpAct_s    = 1'b0;
        digitAct_s = 4'b0000;
      end
      ST_SHOW: begin
        // A blanked leading zero keeps its enable so the scan duty stays even.
        digitAct_s = digitHot_s;
        if (lzbEnableIn && lzbMask_s[idxNext_s]) begin
          segAct_s = 7'h00;
          dpAct_s  = 1'b0;
        end else begin
          segAct_s = hexDecode(nibble_s);
          dpAct_s  = dpSel_s;
        end
      end
      default: begin
        segAct_s   = 7'h00;
        dpAct_s    = 1'b0;
        digitAct_s = 4'b0000;
      end
    endcase

    frameDoneNext_s = (idxNext_s == 2'd3) && (cntNext_s == CNT_LAST);
  end

  // Scan counters, value buffers and pending flag.
  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      cnt_r     <= '0;
      idx_r     <= 2'd0;
      shVal_r   <= 16'h0000;
      shDp_r    <= 4'h0;
      acVal_r   <= 16'h0000;
      acDp_r    <= 4'h0;
      pending_r <= 1'b0;
    end else begin
      cnt_r     <= cntNext_s;
      idx_r     <= idxNext_s;
      shVal_r   <= shValNext_s;
      shDp_r    <= shDpNext_s;
      acVal_r   <= acValNext_s;
      acDp_r    <= acDpNext_s;
      pending_r <= pendingNext_s;
    end
  end

  // Registered outputs with board polarity applied last.
  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      segOut       <= {7{SEG_ACTIVE_LOW}};
      dpOut        <= SEG_ACTIVE_LOW;
      digitOut     <= {4{DIGIT_ACTIVE_LOW}};
      digitIdxOut  <= 2'd0;
      frameDoneOut <= 1'b0;
    end else begin
      segOut       <= segAct_s ^ {7{SEG_ACTIVE_LOW}};
      dpOut        <= dpAct_s ^ SEG_ACTIVE_LOW;
      digitOut     <= digitAct_s ^ {4{DIGIT_ACTIVE_LOW}};
      digitIdxOut  <= idxNext_s;
      frameDoneOut <= frameDoneNext_s;
    end
  end

endmodule
